bcd_converter_n: RTL and testbench
==================================

# bcd_converter_n

Parametrised binary-to-BCD converter using sequential double-dabble (shift-add-3), with datapath and control in one block. It converts an IN_WIDTH-bit operand into DIGITS packed BCD digits. It adds several things the fixed two-digit controller did not have: all digits adjusted in parallel, a start/busy/done handshake, a sticky overflow flag and a configurable done-hold time. It sits between binary arithmetic results and display or UART formatting logic.

## Interface
- IN_WIDTH, 8, operand width in bits (≥2)
- DIGITS, 3, BCD digits produced (≥1); full range needs 10^DIGITS > 2^IN_WIDTH−1
- DONE_HOLD, 1, cycles out_DONE stays high (≥1, ≤255)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_init  input  1  start request, sampled only in IDLE
- in_data  input  IN_WIDTH  operand, captured on the accepting edge
- out_BCD  output  4*DIGITS  result, digit 0 in [3:0]; registered, held until next accept
- out_BUSY  output  1  high from accept until DONE exits
- out_DONE  output  1  result-valid strobe, DONE_HOLD cycles
- out_OVF  output  1  result truncated (a bit shifted out of top digit); valid with out_DONE

## Operation
- Registers: operand shift reg (IN_WIDTH), scratch BCD reg (4*DIGITS), bit counter (clog2(IN_WIDTH+1)), hold counter (8 bits), overflow flag.
- States: IDLE, ADJUST, SHIFT, DONE. Any illegal encoding goes to IDLE.
- IDLE: all outputs low except out_BCD/out_OVF (held).
  - When in_init=1: load operand ← in_data, scratch ← 0, counter ← IN_WIDTH, ovf ← 0, go ADJUST.
- ADJUST: every scratch digit ≥5 gets +3, all digits in the same cycle (4-bit add, no carry between digits). Go SHIFT.
- SHIFT: {scratch, operand} shifted left 1. Bit leaving scratch MSB sets ovf (sticky). Counter decrements.
  - Counter becomes 0 → out_BCD ← shifted scratch, out_OVF ← ovf, hold ← DONE_HOLD, go DONE.
  - Else → ADJUST.
- DONE: out_DONE=1, out_BUSY=1. Hold decrements each cycle; exit to IDLE on the cycle it reads 1.
- in_init outside IDLE is ignored, not queued.
- Digits ≥10 never appear in out_BCD when out_OVF=0.

## Timing
- Reset (async, any state): state IDLE, out_BCD=0, out_BUSY=0, out_DONE=0, out_OVF=0, all counters 0.
  - Takes effect immediately; a conversion in flight is abandoned and no out_DONE is produced.
- Accept edge k (IDLE, in_init=1): out_BUSY high from k.
- IN_WIDTH ADJUST/SHIFT pairs occupy edges k+1 … k+2·IN_WIDTH.
- out_BCD and out_OVF update at edge k+2·IN_WIDTH.
- out_DONE is high for DONE_HOLD cycles from that edge. out_BUSY falls with it.
- Earliest next accept: edge k+2·IN_WIDTH+DONE_HOLD+1. If in_init is held high continuously, conversions run back-to-back at that rate.
- in_data needs to be stable only at the accept edge.

## Configuration
- BCD_SIGNED_EN defined:
  - in_data is two's complement; captured operand is |in_data|. Magnitude −2^(IN_WIDTH−1) is represented exactly.
  - Adds port out_SIGN (output, 1), registered at accept, held like out_BCD, reset 0.
  - A zero result always has out_SIGN=0.
- Undefined: in_data is unsigned and the out_SIGN port does not exist.
- Cycle timing is identical in both builds.

## Test plan
- Defaults, in_data=8'd255 → out_DONE at accept+16 for 1 cycle, out_BCD=12'h255, out_OVF=0, out_BUSY high 17 cycles.
- in_data=0 then 8'd99 back-to-back with in_init held → 12'h000 then 12'h099; second accept at first-accept+18.
- DIGITS=2, in_data=8'd200 → out_OVF=1, out_DONE still asserted on schedule; then 8'd42 → out_OVF=0, out_BCD=8'h42.
- Pulse in_init mid-conversion and during DONE → ignored, single result; DONE_HOLD=5 → out_DONE high exactly 5 cycles.
- Assert rst between clock edges at accept+7 → all outputs 0 immediately, no out_DONE; next in_init=8'd7 → 12'h007.
- BCD_SIGNED_EN, in_data=8'h80 → out_SIGN=1, out_BCD=12'h128; 8'hFF → out_SIGN=1, 12'h001; 8'h00 → out_SIGN=0.

Source files
------------

// File: rtl/bcd_converter_n.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake and sticky overflow.
// Build option BCD_SIGNED_EN: two's-complement operand, magnitude is converted and out_SIGN is added.

module bcd_converter_n #(
    parameter int IN_WIDTH  = 8,
    parameter int DIGITS    = 3,
    parameter int DONE_HOLD = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_init,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic [4*DIGITS-1:0] out_BCD,
    output logic                out_BUSY,
    output logic                out_DONE,
    output logic                out_OVF
`ifdef BCD_SIGNED_EN
    ,
    output logic                out_SIGN
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADJUST = 2'd1,
        S_SHIFT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q;
    logic [IN_WIDTH-1:0] operand_q;
    logic [BCD_W-1:0]    scratch_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [7:0]          hold_q;
    logic                ovf_q;
    logic [BCD_W-1:0]    bcd_q;
    logic                busy_q;
    logic                done_q;
    logic                ovf_out_q;
`ifdef BCD_SIGNED_EN
    logic                sign_q;
`endif

    logic [BCD_W-1:0]    scratch_adj_d;
    logic [BCD_W-1:0]    scratch_shift_d;
    logic [IN_WIDTH-1:0] operand_shift_d;
    logic [IN_WIDTH-1:0] operand_load_d;
    logic                ovf_shift_d;
    logic [CNT_W-1:0]    cnt_dec_d;
    logic [7:0]          hold_dec_d;

    // Every digit is corrected independently; a digit >= 5 doubles past 9 on the next shift.
    always_comb begin
        // NOTE: assign a default before any conditional update so no latch is inferred.
        scratch_adj_d = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign {scratch_shift_d, operand_shift_d} = {scratch_q, operand_q} << 1;
    assign ovf_shift_d = ovf_q | scratch_q[BCD_W-1];
    assign cnt_dec_d   = cnt_q - CNT_W'(1);
    assign hold_dec_d  = hold_q - 8'd1;

`ifdef BCD_SIGNED_EN
    // Negation of the most negative value wraps to 2^(IN_WIDTH-1), which is its exact unsigned magnitude.
    assign operand_load_d = in_data[IN_WIDTH-1] ? -in_data : in_data;
`else
    assign operand_load_d = in_data;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            operand_q <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_out_q <= 1'b0;
`ifdef BCD_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_init) begin
                        operand_q <= operand_load_d;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(IN_WIDTH);
                        ovf_q     <= 1'b0;
                        busy_q    <= 1'b1;
`ifdef BCD_SIGNED_EN
                        sign_q    <= in_data[IN_WIDTH-1];
`endif
                        state_q   <= S_ADJUST;
                    end
                end
                S_ADJUST: begin
                    scratch_q <= scratch_adj_d;
                    state_q   <= S_SHIFT;
                end
                S_SHIFT: begin
                    scratch_q <= scratch_shift_d;
                    operand_q <= operand_shift_d;
                    ovf_q     <= ovf_shift_d;
                    cnt_q     <= cnt_dec_d;
                    if (cnt_dec_d == '0) begin
                        bcd_q     <= scratch_shift_d;
                        ovf_out_q <= ovf_shift_d;
                        hold_q    <= 8'(DONE_HOLD);
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        state_q   <= S_ADJUST;
                    end
                end
                S_DONE: begin
                    hold_q <= hold_dec_d;
                    if (hold_q <= 8'd1) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_BCD  = bcd_q;
    assign out_BUSY = busy_q;
    assign out_DONE = done_q;
    assign out_OVF  = ovf_out_q;
`ifdef BCD_SIGNED_EN
    assign out_SIGN = sign_q;
`endif

endmodule

// File: tb/tb_bcd_converter_n.sv
// Scoreboard bench for bcd_converter_n: three instances (defaults, DIGITS=2, DONE_HOLD=5).
// Stimulus pushes expected results; a negedge monitor checks value, timing and strobe widths.

module tb_bcd_converter_n;

    localparam int W = 8;
`ifdef BCD_SIGNED_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    typedef struct {
        int          id;
        logic [11:0] bcd;
        logic        ovf;
        logic        sgn;
        int          cyc;
        int          hold;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  init_r = '0;
    logic [7:0]  data_r [3];

    logic [11:0] bcd0, bcd2;
    logic [7:0]  bcd1;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        ovf0, ovf1, ovf2;
`ifdef BCD_SIGNED_EN
    logic        sign0, sign1, sign2;
`endif

    logic [11:0] bcd_m  [3];
    logic        busy_m [3];
    logic        done_m [3];
    logic        ovf_m  [3];
    logic        sign_m [3];

    exp_t sb_q[$];
    exp_t cur [3];
    int   busy_cnt [3];
    int   done_cnt [3];
    logic prev_busy [3];
    logic prev_done [3];

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    bcd_converter_n #(.IN_WIDTH(W), .DIGITS(3), .DONE_HOLD(1)) u0 (
        .clk(clk), .rst(rst), .in_init(init_r[0]), .in_data(data_r[0]),
        .out_BCD(bcd0), .out_BUSY(busy0), .out_DONE(done0), .out_OVF(ovf0)
`ifdef BCD_SIGNED_EN
        , .out_SIGN(sign0)
`endif
    );

    bcd_converter_n #(.IN_WIDTH(W), .DIGITS(2), .DONE_HOLD(1)) u1 (
        .clk(clk), .rst(rst), .in_init(init_r[1]), .in_data(data_r[1]),
        .out_BCD(bcd1), .out_BUSY(busy1), .out_DONE(done1), .out_OVF(ovf1)
`ifdef BCD_SIGNED_EN
        , .out_SIGN(sign1)
`endif
    );

    bcd_converter_n #(.IN_WIDTH(W), .DIGITS(3), .DONE_HOLD(5)) u2 (
        .clk(clk), .rst(rst), .in_init(init_r[2]), .in_data(data_r[2]),
        .out_BCD(bcd2), .out_BUSY(busy2), .out_DONE(done2), .out_OVF(ovf2)
`ifdef BCD_SIGNED_EN
        , .out_SIGN(sign2)
`endif
    );

    always_comb begin
        bcd_m[0]  = bcd0;
        bcd_m[1]  = {4'h0, bcd1};
        bcd_m[2]  = bcd2;
        busy_m[0] = busy0;
        busy_m[1] = busy1;
        busy_m[2] = busy2;
        done_m[0] = done0;
        done_m[1] = done1;
        done_m[2] = done2;
        ovf_m[0]  = ovf0;
        ovf_m[1]  = ovf1;
        ovf_m[2]  = ovf2;
        sign_m[0] = 1'b0;
        sign_m[1] = 1'b0;
        sign_m[2] = 1'b0;
`ifdef BCD_SIGNED_EN
        sign_m[0] = sign0;
        sign_m[1] = sign1;
        sign_m[2] = sign2;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push_exp(input int d, input logic [11:0] eb, input logic eo,
                            input logic es, input int cyc, input int hold);
        exp_t e;
        e.id   = d;
        e.bcd  = eb;
        e.ovf  = eo;
        e.sgn  = es;
        e.cyc  = cyc;
        e.hold = hold;
        sb_q.push_back(e);
    endtask

    // Returns at the negedge following the accept edge (edge_n == accept edge).
    task automatic launch(input int d, input logic [7:0] v, input logic [11:0] eb,
                          input logic eo, input logic es, input int hold);
        @(negedge clk);
        data_r[d] = v;
        init_r[d] = 1'b1;
        push_exp(d, eb, eo, es, edge_n + 1 + 2 * W, hold);
        @(negedge clk);
        init_r[d] = 1'b0;
    endtask

    task automatic wait_edge(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    task automatic wait_idle(input int d);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while ((busy_m[d] || sb_q.size() != 0) && i < 200);
        check($sformatf("dut%0d_results_pending", d), sb_q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per out_DONE rising edge and measures strobe widths.
    initial begin
        for (int d = 0; d < 3; d++) begin
            busy_cnt[d]  = 0;
            done_cnt[d]  = 0;
            prev_busy[d] = 1'b0;
            prev_done[d] = 1'b0;
            cur[d].hold  = 1;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst) begin
                    busy_cnt[d]  = 0;
                    done_cnt[d]  = 0;
                    prev_busy[d] = 1'b0;
                    prev_done[d] = 1'b0;
                end else begin
                    if (busy_m[d]) busy_cnt[d]++;
                    if (done_m[d] && !prev_done[d]) begin
                        if (sb_q.size() == 0 || sb_q[0].id != d) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL dut%0d_unexpected_done: got a result at edge %0d, want none", d, edge_n);
                        end else begin
                            cur[d] = sb_q.pop_front();
                            check($sformatf("dut%0d_bcd", d), bcd_m[d], cur[d].bcd);
                            check($sformatf("dut%0d_ovf", d), ovf_m[d], cur[d].ovf);
                            check($sformatf("dut%0d_done_edge", d), edge_n, cur[d].cyc);
`ifdef BCD_SIGNED_EN
                            check($sformatf("dut%0d_sign", d), sign_m[d], cur[d].sgn);
`endif
                        end
                        done_cnt[d] = 1;
                    end else if (done_m[d]) begin
                        done_cnt[d]++;
                    end
                    if (!done_m[d] && prev_done[d])
                        check($sformatf("dut%0d_done_width", d), done_cnt[d], cur[d].hold);
                    if (!busy_m[d] && prev_busy[d]) begin
                        check($sformatf("dut%0d_busy_width", d), busy_cnt[d], 2 * W + cur[d].hold);
                        busy_cnt[d] = 0;
                    end
                    prev_busy[d] = busy_m[d];
                    prev_done[d] = done_m[d];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        for (int d = 0; d < 3; d++) data_r[d] = 8'h00;

        #1 rst = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d_reset_bcd", d), bcd_m[d], 12'h000);
            check($sformatf("dut%0d_reset_busy", d), busy_m[d], 1'b0);
            check($sformatf("dut%0d_reset_done", d), done_m[d], 1'b0);
            check($sformatf("dut%0d_reset_ovf", d), ovf_m[d], 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;

        // Full-scale operand (signed build: -1) and the signed-minimum pattern.
        launch(0, 8'd255, SB ? 12'h001 : 12'h255, 1'b0, SB, 1);
        wait_idle(0);
        launch(0, 8'h80, 12'h128, 1'b0, SB, 1);
        wait_idle(0);

        // Back-to-back with in_init held: second accept lands 18 edges after the first.
        @(negedge clk);
        data_r[0] = 8'd0;
        init_r[0] = 1'b1;
        k = edge_n + 1;
        push_exp(0, 12'h000, 1'b0, 1'b0, k + 2 * W, 1);
        push_exp(0, 12'h099, 1'b0, 1'b0, k + 2 * W + 18, 1);
        @(negedge clk);
        data_r[0] = 8'd99;
        wait_edge(k + 18);
        init_r[0] = 1'b0;
        wait_idle(0);

        // Asynchronous reset mid-conversion: outputs clear at once, no result follows.
        @(negedge clk);
        data_r[0] = 8'd200;
        init_r[0] = 1'b1;
        k = edge_n + 1;
        @(negedge clk);
        init_r[0] = 1'b0;
        wait_edge(k + 7);
        check("dut0_busy_before_reset", busy_m[0], 1'b1);
        check("dut0_bcd_held_before_reset", bcd_m[0], 12'h099);
        #2 rst = 1'b1;
        #1;
        check("dut0_async_reset_bcd", bcd_m[0], 12'h000);
        check("dut0_async_reset_busy", busy_m[0], 1'b0);
        check("dut0_async_reset_done", done_m[0], 1'b0);
        check("dut0_async_reset_ovf", ovf_m[0], 1'b0);
        check("dut0_async_reset_sign", sign_m[0], 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (30) @(negedge clk);
        launch(0, 8'd7, 12'h007, 1'b0, 1'b0, 1);
        wait_idle(0);

        // Two-digit instance: overflow, recovery, largest fitting value, first overflowing value.
        launch(1, 8'd200, SB ? 12'h056 : 12'h000, SB ? 1'b0 : 1'b1, SB, 1);
        wait_idle(1);
        launch(1, 8'd42, 12'h042, 1'b0, 1'b0, 1);
        wait_idle(1);
        repeat (3) @(negedge clk);
        check("dut1_bcd_held_idle", bcd_m[1], 12'h042);
        check("dut1_ovf_held_idle", ovf_m[1], 1'b0);
        launch(1, 8'd99, 12'h099, 1'b0, 1'b0, 1);
        wait_idle(1);
        launch(1, 8'd100, 12'h000, 1'b1, 1'b0, 1);
        wait_idle(1);

        // DONE_HOLD=5 instance: in_init pulses during conversion and during DONE are ignored.
        launch(2, 8'd123, 12'h123, 1'b0, 1'b0, 5);
        k = edge_n;
        wait_edge(k + 5);
        data_r[2] = 8'd77;
        init_r[2] = 1'b1;
        @(negedge clk);
        init_r[2] = 1'b0;
        wait_edge(k + 18);
        check("dut2_done_during_hold", done_m[2], 1'b1);
        init_r[2] = 1'b1;
        @(negedge clk);
        init_r[2] = 1'b0;
        wait_idle(2);
        repeat (40) @(negedge clk);
        check("dut2_bcd_held_after_pulses", bcd_m[2], 12'h123);
        launch(2, 8'd45, 12'h045, 1'b0, 1'b0, 5);
        wait_idle(2);

        repeat (5) @(negedge clk);
        check("final_results_pending", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
